// File: rtl/sel_sequencer.sv
// Select-code sequencer: steps a decoder select through 0..last, holding each
// code for dwell+1 cycles, in one-shot or continuous mode.
module sel_sequencer #(
   parameter int N = 3,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         stop,
   input  logic         hold,
   input  logic         cont,
   input  logic [N-1:0] last,
   input  logic [W-1:0] dwell,
   output logic [N-1:0] sel,
   output logic         enab,
   output logic         busy,
   output logic         done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t       state;
   logic [N-1:0] last_q;
   logic [W-1:0] dwell_q;
   logic [W-1:0] cnt;
   logic         cont_q;

   // Configuration is captured at start so RUN is immune to input changes;
   // stop outranks hold, which in turn outranks normal progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sel     <= '0;
         enab    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         last_q  <= '0;
         dwell_q <= '0;
         cont_q  <= 1'b0;
         cnt     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  last_q  <= last;
                  dwell_q <= dwell;
                  cont_q  <= cont;
                  sel     <= '0;
                  cnt     <= '0;
                  state   <= RUN;
                  enab    <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            RUN: begin
               if (stop) begin
                  state <= IDLE;
                  sel   <= '0;
                  cnt   <= '0;
                  enab  <= 1'b0;
                  busy  <= 1'b0;
               end else if (hold) begin
                  enab <= 1'b0;
               end else begin
                  enab <= 1'b1;
                  if (cnt < dwell_q) begin
                     cnt <= cnt + 1'b1;
                  end else begin
                     cnt <= '0;
                     if (sel != last_q) begin
                        sel <= sel + 1'b1;
                     end else if (cont_q) begin
                        sel <= '0;
                     end else begin
                        // One-shot completion: terminal code has finished its dwell.
                        state <= IDLE;
                        sel   <= '0;
                        enab  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sel_sequencer.sv
// Self-checking bench for sel_sequencer: directed scenarios plus random traffic,
// compared every cycle against a progress-count reference model.
module tb_sel_sequencer;

   localparam int N = 3;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst, start, stop, hold, cont;
   logic [N-1:0] last;
   logic [W-1:0] dwell;
   logic [N-1:0] sel;
   logic         enab, busy, done;

   int checks = 0;
   int failures = 0;

   // Model: a run is a count of productive edges; the code is that count
   // divided by the per-code length.
   bit mRun, mHeld, mDone, mCont;
   int mP, mLast, mDwell;

   sel_sequencer #(.N(N), .W(W)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold),
      .cont(cont), .last(last), .dwell(dwell),
      .sel(sel), .enab(enab), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic updateModel();
      int span;
      mDone = 1'b0;
      if (rst) begin
         mRun = 1'b0; mP = 0; mHeld = 1'b0;
      end else if (!mRun) begin
         if (start) begin
            mLast = int'(last); mDwell = int'(dwell); mCont = cont;
            mRun = 1'b1; mP = 0; mHeld = 1'b0;
         end
      end else if (stop) begin
         mRun = 1'b0;
      end else if (hold) begin
         mHeld = 1'b1;
      end else begin
         mHeld = 1'b0;
         mP++;
         span = (mLast + 1) * (mDwell + 1);
         if (mP == span) begin
            mP = 0;
            if (!mCont) begin
               mRun = 1'b0;
               mDone = 1'b1;
            end
         end
      end
   endtask

   // One clock: inputs already set by caller; model and DUT both see this edge.
   task automatic applyStimulus();
      @(posedge clk);
      updateModel();
      #1;
      checkOutput("sel",  int'(sel),  mRun ? mP / (mDwell + 1) : 0);
      checkOutput("enab", int'(enab), int'(mRun && !mHeld));
      checkOutput("busy", int'(busy), int'(mRun));
      checkOutput("done", int'(done), int'(mDone));
   endtask

   task automatic idleInputs();
      rst = 0; start = 0; stop = 0; hold = 0; cont = 0; last = '0; dwell = '0;
   endtask

   task automatic launch(input int l, input int d, input bit c);
      start = 1; last = N'(l); dwell = W'(d); cont = c;
      applyStimulus();
      start = 0; last = '0; dwell = '0; cont = 0;
   endtask

   initial begin
      idleInputs();
      mRun = 0; mHeld = 0; mDone = 0; mCont = 0; mP = 0; mLast = 0; mDwell = 0;
      rst = 1;
      repeat (2) applyStimulus();
      rst = 0;
      checkOutput("rst_sel", int'(sel), 0);
      checkOutput("rst_enab", int'(enab), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);

      // One-shot last=3 dwell=0: sel 0..3 then a single done pulse.
      launch(3, 0, 0);
      checkOutput("os_sel0", int'(sel), 0);
      for (int k = 1; k <= 3; k++) begin
         applyStimulus();
         checkOutput("os_sel", int'(sel), k);
         checkOutput("os_enab", int'(enab), 1);
      end
      applyStimulus();
      checkOutput("os_done", int'(done), 1);
      checkOutput("os_busy", int'(busy), 0);
      applyStimulus();
      checkOutput("os_done_width", int'(done), 0);

      // Dwell=1, last=1.
      launch(1, 1, 0);
      repeat (5) applyStimulus();

      // Hold on sel=1, last=2.
      launch(2, 0, 0);
      applyStimulus();
      hold = 1;
      applyStimulus();
      checkOutput("hold_sel", int'(sel), 1);
      checkOutput("hold_enab", int'(enab), 0);
      applyStimulus();
      hold = 0;
      repeat (3) applyStimulus();

      // Continuous full range, start ignored in RUN, then stop.
      launch(7, 0, 1);
      start = 1;
      repeat (20) applyStimulus();
      start = 0;
      stop = 1; hold = 1;
      applyStimulus();
      stop = 0; hold = 0;
      checkOutput("stop_busy", int'(busy), 0);
      checkOutput("stop_done", int'(done), 0);

      // Stop on final one-shot cycle.
      launch(1, 0, 0);
      applyStimulus();
      stop = 1;
      applyStimulus();
      stop = 0;
      checkOutput("stop_final_done", int'(done), 0);

      // Reset mid-run at sel=2, then restart.
      launch(5, 0, 0);
      repeat (2) applyStimulus();
      rst = 1;
      applyStimulus();
      rst = 0;
      checkOutput("midrst_busy", int'(busy), 0);
      launch(5, 0, 0);
      checkOutput("restart_sel", int'(sel), 0);
      repeat (8) applyStimulus();

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 199) == 0);
         start = ($urandom_range(0, 9) < 3);
         stop  = ($urandom_range(0, 39) == 0);
         hold  = ($urandom_range(0, 6) == 0);
         cont  = ($urandom_range(0, 3) == 0);
         last  = N'($urandom);
         dwell = W'($urandom_range(0, 9) < 8 ? $urandom_range(0, 2) : $urandom_range(0, 15));
         applyStimulus();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
